// File: rtl/seg7_capture.sv
// rtl/seg7_capture.sv - recovers BCD digits from a multiplexed active-low 7-segment bus
module seg7_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    localparam int IDXW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic [NUM_DIGITS-1:0]   err,
    output logic                    upd_valid,
    output logic [IDXW-1:0]         upd_idx,
    output logic                    frame_done
);

    typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0] CNT_SAT  = 8'(STABLE_CYCLES);

    state_t                  state;
    logic [6:0]              seg_s, last_seg;
    logic [NUM_DIGITS-1:0]   an_s, last_an;
    logic [7:0]              cnt;
    logic [NUM_DIGITS-1:0]   seen, seen_next;

    logic                    one_hot, same;
    logic [IDXW-1:0]         idx;
    int unsigned             low_count;
    logic [3:0]              dec_code;
    logic                    dec_blank, dec_err;

    always_comb begin
        low_count = 0;
        idx       = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_s[i]) begin
                low_count = low_count + 1;
                idx       = IDXW'(i);
            end
        end
        one_hot   = (low_count == 1);
        same      = (seg_s == last_seg) && (an_s == last_an);
        seen_next = seen | (NUM_DIGITS'(1) << idx);
    end

    always_comb begin
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (seg_s)
            7'b1000000: dec_code = 4'd0;
            7'b1111001: dec_code = 4'd1;
            7'b0100100: dec_code = 4'd2;
            7'b0110000: dec_code = 4'd3;
            7'b0011001: dec_code = 4'd4;
            7'b0010010: dec_code = 4'd5;
            7'b0000010: dec_code = 4'd6;
            7'b1111000: dec_code = 4'd7;
            7'b0000000: dec_code = 4'd8;
            7'b0010000: dec_code = 4'd9;
            7'b1111111: begin
                dec_code  = 4'hF;
                dec_blank = 1'b1;
            end
            default: begin
                dec_code = 4'hE;
                dec_err  = 1'b1;
            end
        endcase
    end

    // last_* hold the previous sample so any change of S, including a strobe move, restarts the window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            seg_s      <= '1;
            an_s       <= '1;
            last_seg   <= '1;
            last_an    <= '1;
            cnt        <= '0;
            seen       <= '0;
            digits     <= '1;
            blank      <= '1;
            err        <= '0;
            upd_valid  <= 1'b0;
            upd_idx    <= '0;
            frame_done <= 1'b0;
        end else begin
            seg_s      <= seg_n;
            an_s       <= an_n;
            last_seg   <= seg_s;
            last_an    <= an_s;
            upd_valid  <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (one_hot) begin
                        state <= COUNT;
                        cnt   <= 8'd1;
                    end else begin
                        cnt <= '0;
                    end
                end
                COUNT: begin
                    if (!same) begin
                        if (one_hot) begin
                            cnt <= 8'd1;
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end else if (cnt == CNT_LAST) begin
                        state                <= HOLD;
                        cnt                  <= CNT_SAT;
                        digits[4*idx +: 4]   <= dec_code;
                        blank[idx]           <= dec_blank;
                        err[idx]             <= dec_err;
                        upd_valid            <= 1'b1;
                        upd_idx              <= idx;
                        if (&seen_next) begin
                            frame_done <= 1'b1;
                            seen       <= '0;
                        end else begin
                            seen <= seen_next;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (!same) begin
                        if (one_hot) begin
                            state <= COUNT;
                            cnt   <= 8'd1;
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_capture.sv
// tb/tb_seg7_capture.sv - self-checking bench for seg7_capture
module tb_seg7_capture;

    localparam int ND = 4;
    localparam int SC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic [15:0] digits;
    logic [3:0]  blank, err;
    logic        upd_valid, frame_done;
    logic [1:0]  upd_idx;

    logic [6:0]  seg_b;
    logic [0:0]  an_b;
    logic [3:0]  digits_b;
    logic [0:0]  blank_b, err_b;
    logic        upd_valid_b, frame_done_b;
    logic [0:0]  upd_idx_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seg7_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk(clk), .rst(rst), .seg_n(seg_n), .an_n(an_n),
        .digits(digits), .blank(blank), .err(err),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .frame_done(frame_done)
    );

    seg7_capture #(.NUM_DIGITS(1), .STABLE_CYCLES(2)) dut_b (
        .clk(clk), .rst(rst), .seg_n(seg_b), .an_n(an_b),
        .digits(digits_b), .blank(blank_b), .err(err_b),
        .upd_valid(upd_valid_b), .upd_idx(upd_idx_b), .frame_done(frame_done_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a capture happens at an edge when the last SC samples are one identical
    // one-hot value and the sample before them (or the reset sample) differed.
    logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    logic [10:0] hist[$];
    logic [15:0] m_digits;
    logic [3:0]  m_blank, m_err, m_seen;
    logic        m_valid, m_frame;
    int          m_idx;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist.delete();
            m_digits = 16'hFFFF; m_blank = 4'hF; m_err = 4'h0; m_seen = 4'h0;
            m_valid = 1'b0; m_frame = 1'b0; m_idx = 0;
        end else begin
            int n;
            bit ok;
            m_valid = 1'b0;
            m_frame = 1'b0;
            n = hist.size();
            if (n >= SC) begin
                logic [10:0] v;
                v  = hist[n-1];
                ok = ($countones(~v[3:0]) == 1);
                for (int j = 1; j < SC; j++) if (hist[n-1-j] != v) ok = 0;
                if (n > SC && hist[n-1-SC] == v) ok = 0;
                if (ok) begin
                    logic [3:0] code;
                    code = 4'hE;
                    for (int k = 0; k < 10; k++) if (pat[k] == v[10:4]) code = 4'(k);
                    if (v[10:4] == 7'h7F) code = 4'hF;
                    for (int k = 0; k < ND; k++) if (!v[k]) m_idx = k;
                    m_digits[4*m_idx +: 4] = code;
                    m_blank[m_idx] = (code == 4'hF);
                    m_err[m_idx]   = (code == 4'hE);
                    m_valid = 1'b1;
                    m_seen[m_idx] = 1'b1;
                    if (m_seen == 4'hF) begin
                        m_frame = 1'b1;
                        m_seen  = 4'h0;
                    end
                end
            end
            hist.push_back({seg_n, an_n});
            if (hist.size() > SC + 1) void'(hist.pop_front());
        end
    end

    int pulses = 0, frames = 0, fr_idx = -1;
    always @(negedge clk) begin
        chk("upd_valid", {31'd0, upd_valid}, {31'd0, m_valid});
        chk("frame_done", {31'd0, frame_done}, {31'd0, m_frame});
        chk("digits", {16'd0, digits}, {16'd0, m_digits});
        chk("blank", {28'd0, blank}, {28'd0, m_blank});
        chk("err", {28'd0, err}, {28'd0, m_err});
        if (m_valid) chk("upd_idx", {30'd0, upd_idx}, 32'(m_idx));
        if (upd_valid) pulses++;
        if (frame_done) begin
            frames++;
            fr_idx = int'(upd_idx);
        end
    end

    task automatic drive(input logic [6:0] s, input logic [3:0] a, input int n);
        seg_n = s;
        an_n  = a;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int p0, f0;
        rst = 1'b1; seg_n = 7'h7F; an_n = 4'hF; seg_b = 7'h7F; an_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_digits", {16'd0, digits}, 32'h0000FFFF);
        chk("rst_blank", {28'd0, blank}, 32'hF);
        chk("rst_err", {28'd0, err}, 32'h0);
        chk("rst_upd", {31'd0, upd_valid}, 32'h0);
        rst = 1'b0;
        drive(7'h7F, 4'hF, 1);

        // T1: single digit, latency of SC+1 edges
        p0 = pulses;
        drive(7'b0100100, 4'b1110, 4);
        chk("t1_early", {31'd0, upd_valid}, 32'h0);
        @(posedge clk); #1;
        chk("t1_valid", {31'd0, upd_valid}, 32'h1);
        chk("t1_idx", {30'd0, upd_idx}, 32'h0);
        chk("t1_code", {28'd0, digits[3:0]}, 32'h2);
        chk("t1_blank_err", {30'd0, blank[0], err[0]}, 32'h0);
        repeat (5) @(posedge clk); #1;
        chk("t1_pulses", 32'(pulses - p0), 32'd1);
        drive(7'h7F, 4'hF, 2);

        // T2: scan of four digits completes a frame at idx 3
        p0 = pulses; f0 = frames;
        drive(7'b1111001, 4'b1110, 8);
        drive(7'b0010000, 4'b1101, 8);
        drive(7'b1111000, 4'b1011, 8);
        drive(7'b1000000, 4'b0111, 8);
        chk("t2_digits", {16'd0, digits}, 32'h0791);
        chk("t2_pulses", 32'(pulses - p0), 32'd4);
        chk("t2_frames", 32'(frames - f0), 32'd1);
        chk("t2_frame_idx", 32'(fr_idx), 32'd3);
        drive(7'h7F, 4'hF, 2);

        // T3: short glitch of 6 before a stable 5
        p0 = pulses;
        drive(7'b0000010, 4'b1110, 3);
        drive(7'b0010010, 4'b1110, 6);
        chk("t3_pulses", 32'(pulses - p0), 32'd1);
        chk("t3_code", {28'd0, digits[3:0]}, 32'h5);

        // T4: two strobes low, then unknown pattern, then blank
        p0 = pulses;
        drive(7'b0010010, 4'b1100, 10);
        chk("t4_multi", 32'(pulses - p0), 32'd0);
        drive(7'b1010101, 4'b1101, 6);
        chk("t4_err_code", {28'd0, digits[7:4]}, 32'hE);
        chk("t4_err_flag", {31'd0, err[1]}, 32'h1);
        drive(7'b1111111, 4'b1101, 6);
        chk("t4_blank_code", {28'd0, digits[7:4]}, 32'hF);
        chk("t4_blank_flags", {30'd0, blank[1], err[1]}, 32'h2);
        drive(7'h7F, 4'hF, 2);

        // T5: reset lands on the capture edge
        drive(7'b0110000, 4'b1110, 4);
        rst = 1'b1;
        #1;
        chk("t5_rst_digits", {16'd0, digits}, 32'h0000FFFF);
        chk("t5_rst_flags", {24'd0, blank, err}, 32'hF0);
        @(posedge clk); #1;
        chk("t5_no_pulse", {31'd0, upd_valid}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk); #1;
        chk("t5_early", {31'd0, upd_valid}, 32'h0);
        @(posedge clk); #1;
        chk("t5_valid", {31'd0, upd_valid}, 32'h1);
        chk("t5_code", {28'd0, digits[3:0]}, 32'h3);

        // T6: single-digit instance, two-sample window
        seg_b = 7'b0011001; an_b = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("t6_early", {31'd0, upd_valid_b}, 32'h0);
        @(posedge clk); #1;
        chk("t6_valid", {31'd0, upd_valid_b}, 32'h1);
        chk("t6_idx", {31'd0, upd_idx_b}, 32'h0);
        chk("t6_code", {28'd0, digits_b}, 32'h4);
        chk("t6_frame", {31'd0, frame_done_b}, 32'h1);
        @(posedge clk); #1;
        chk("t6_once", {31'd0, upd_valid_b}, 32'h0);
        seg_b = 7'b1111001;
        repeat (2) @(posedge clk); #1;
        chk("t6b_early", {31'd0, upd_valid_b}, 32'h0);
        @(posedge clk); #1;
        chk("t6b_valid", {30'd0, upd_valid_b, frame_done_b}, 32'h3);
        chk("t6b_code", {28'd0, digits_b}, 32'h1);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
